seg_scan_mux: RTL and testbench

- Downstream of the display controller: takes its four registered 8-bit segment codes (active-low, bit 7 = DP) and time-multiplexes them onto the board's shared cathode bus and four active-low anodes.
- Inserts a blanking gap between digits to suppress ghosting.
- Latches a full frame at a time so the display never tears.
- Issues a per-frame tick for upstream timing.

---
 rtl/seg_pkg.sv | 14 +
 rtl/seg_slot_timer.sv | 31 +++
 rtl/seg_scan_mux.sv | 121 ++++++++++++
 tb/tb_seg_scan_mux.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants, scan state type and anode-select helper for the segment scanner.
// Pure definitions: no latency and no flow control.
package seg_pkg;
    localparam int         NUM_DIGITS = 4;
    localparam logic [7:0] SEG_OFF    = 8'hFF;
    localparam logic [3:0] ANODE_OFF  = 4'hF;

    typedef enum logic {BLANK, DRIVE} scanState;

    // Active-low one-hot select for digit idx.
    function automatic logic [3:0] anodeSel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction
endpackage

// File: rtl/seg_slot_timer.sv
// Per-digit slot counter: strobes slot start, end of blanking and end of slot.
// Strobes are combinational from the counter; Clear restarts the slot on the next edge.
module seg_slot_timer #(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 1000
) (
    input  logic Clk100M,
    input  logic RstN,
    input  logic Clear,
    output logic SlotStart,
    output logic BlankDone,
    output logic SlotDone
);
    localparam int CW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;

    logic [CW-1:0] cnt;

    // Counter only ever counts 0..DIGIT_TICKS-1, so it never wraps mid-slot.
    always_ff @(posedge Clk100M or negedge RstN) begin
        if (!RstN)
            cnt <= '0;
        else if (Clear || SlotDone)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign SlotStart = (cnt == '0);
    assign BlankDone = (cnt == CW'(BLANK_TICKS - 1));
    assign SlotDone  = (cnt == CW'(DIGIT_TICKS - 1));
endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit cathode/anode scanner with per-slot blanking and frame-wide input snapshot; outputs registered (1 cycle).
// No backpressure: free-running while Enable is high; optional SEG_BLINK_EN adds masked digit blinking.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIGIT_TICKS  = 100000,
    parameter int BLANK_TICKS  = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       Clk100M,
    input  logic       RstN,
    input  logic       Enable,
    input  logic [7:0] SegIn0,
    input  logic [7:0] SegIn1,
    input  logic [7:0] SegIn2,
    input  logic [7:0] SegIn3,
`ifdef SEG_BLINK_EN
    input  logic [3:0] BlinkMask,
`endif
    output logic [3:0] Anode,
    output logic [7:0] Cathode,
    output logic       FrameTick
);
    scanState                        state;
    logic [1:0]                      idx;
    logic [NUM_DIGITS-1:0][7:0]      snap;
    logic                            slotStart;
    logic                            blankDone;
    logic                            slotDone;
    logic                            frameStart;
    logic                            frameEnd;
    logic                            blankDigit;

    seg_slot_timer #(
        .DIGIT_TICKS(DIGIT_TICKS),
        .BLANK_TICKS(BLANK_TICKS)
    ) u_timer (
        .Clk100M  (Clk100M),
        .RstN     (RstN),
        .Clear    (!Enable),
        .SlotStart(slotStart),
        .BlankDone(blankDone),
        .SlotDone (slotDone)
    );

    assign frameStart = slotStart && (idx == 2'd0);
    assign frameEnd   = slotDone && (idx == 2'd3);

`ifdef SEG_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [3:0]    maskSnap;
    logic          phase;
    logic [FW-1:0] frameCnt;

    always_ff @(posedge Clk100M or negedge RstN) begin
        if (!RstN) begin
            maskSnap <= '0;
            phase    <= 1'b0;
            frameCnt <= '0;
        end else if (!Enable) begin
            phase    <= 1'b0;
            frameCnt <= '0;
        end else begin
            if (frameStart)
                maskSnap <= BlinkMask;
            if (frameEnd) begin
                if (frameCnt == FW'(BLINK_FRAMES - 1)) begin
                    frameCnt <= '0;
                    phase    <= ~phase;
                end else begin
                    frameCnt <= frameCnt + FW'(1);
                end
            end
        end
    end

    assign blankDigit = phase && maskSnap[idx];
`else
    assign blankDigit = 1'b0;
`endif

    // Enable low wins over any slot advance happening on the same edge.
    always_ff @(posedge Clk100M or negedge RstN) begin
        if (!RstN) begin
            state     <= BLANK;
            idx       <= 2'd0;
            snap      <= {NUM_DIGITS{SEG_OFF}};
            Anode     <= ANODE_OFF;
            Cathode   <= SEG_OFF;
            FrameTick <= 1'b0;
        end else if (!Enable) begin
            state     <= BLANK;
            idx       <= 2'd0;
            Anode     <= ANODE_OFF;
            Cathode   <= SEG_OFF;
            FrameTick <= 1'b0;
        end else begin
            FrameTick <= frameEnd;
            if (frameStart)
                snap <= {SegIn3, SegIn2, SegIn1, SegIn0};
            case (state)
                BLANK: begin
                    Anode   <= ANODE_OFF;
                    Cathode <= SEG_OFF;
                    if (blankDone)
                        state <= DRIVE;
                end
                DRIVE: begin
                    Anode   <= anodeSel(idx);
                    Cathode <= blankDigit ? SEG_OFF : snap[idx];
                    if (slotDone) begin
                        state <= BLANK;
                        idx   <= idx + 2'd1;
                    end
                end
                default: state <= BLANK;
            endcase
        end
    end
endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized scoreboard bench for seg_scan_mux: a frame-position model predicts every output cycle.
// Define SEG_BLINK_EN for both bench and RTL to exercise blinking.
module tb_seg_scan_mux;
    localparam int DT    = 8;
    localparam int BT    = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * DT;
    localparam int NCYC  = 3000;

    logic       Clk100M = 1'b0;
    logic       RstN    = 1'b0;
    logic       Enable  = 1'b1;
    logic [7:0] SegIn0, SegIn1, SegIn2, SegIn3;
    logic [3:0] Anode;
    logic [7:0] Cathode;
    logic       FrameTick;
`ifdef SEG_BLINK_EN
    logic [3:0] BlinkMask;
    logic [3:0] mask;
    logic [3:0] frameMask;
`endif

    seg_scan_mux #(
        .DIGIT_TICKS (DT),
        .BLANK_TICKS (BT),
        .BLINK_FRAMES(BF)
    ) dut (
        .Clk100M  (Clk100M),
        .RstN     (RstN),
        .Enable   (Enable),
        .SegIn0   (SegIn0),
        .SegIn1   (SegIn1),
        .SegIn2   (SegIn2),
        .SegIn3   (SegIn3),
`ifdef SEG_BLINK_EN
        .BlinkMask(BlinkMask),
`endif
        .Anode    (Anode),
        .Cathode  (Cathode),
        .FrameTick(FrameTick)
    );

    always #5 Clk100M = ~Clk100M;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] ca;
        logic       tick;
    } expT;

    expT        q[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         t          = 0;
    logic [7:0] seg[4];
    logic [7:0] frameSeg[4];
    logic       lastDrive  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyInputs();
        SegIn0 = seg[0];
        SegIn1 = seg[1];
        SegIn2 = seg[2];
        SegIn3 = seg[3];
`ifdef SEG_BLINK_EN
        BlinkMask = mask;
`endif
    endtask

    // Output for the coming edge follows from the position t inside the current frame.
    task automatic pushExpected();
        expT e;
        int  slot;
        int  pos;
        e = '{an: 4'hF, ca: 8'hFF, tick: 1'b0};
        if (!Enable) begin
            t = 0;
        end else begin
            slot = (t % FRAME) / DT;
            pos  = t % DT;
            if (t % FRAME == 0) begin
                frameSeg = seg;
`ifdef SEG_BLINK_EN
                frameMask = mask;
`endif
            end
            if (pos >= BT) begin
                e.an[slot] = 1'b0;
                e.ca       = frameSeg[slot];
`ifdef SEG_BLINK_EN
                if (((t / FRAME) / BF) % 2 == 1 && frameMask[slot])
                    e.ca = 8'hFF;
`endif
            end
            e.tick = (t % FRAME == FRAME - 1);
            t++;
        end
        lastDrive = (e.an != 4'hF);
        q.push_back(e);
    endtask

    initial begin : monitor
        expT e;
        forever begin
            @(posedge Clk100M);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("anode", Anode, e.an);
                check("cathode", Cathode, e.ca);
                check("frame_tick", FrameTick, e.tick);
            end
        end
    end

    initial begin : driver
        int   lowLeft  = 0;
        logic resetHit = 1'b0;
        int   pick;
        seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
`ifdef SEG_BLINK_EN
        mask = 4'b0101;
`endif
        applyInputs();
        repeat (3) @(negedge Clk100M);
        check("reset_anode", Anode, 4'hF);
        check("reset_cathode", Cathode, 8'hFF);
        check("reset_tick", FrameTick, 1'b0);

        for (int i = 0; i < NCYC; i++) begin
            @(negedge Clk100M);
            if (i == 0)
                RstN = 1'b1;
            if (!RstN) begin
                RstN = 1'b1;
                t    = 0;
            end
            if (lowLeft > 0) begin
                lowLeft--;
                if (lowLeft == 0)
                    Enable = 1'b1;
            end
            if (i == 12)
                seg[2] = 8'h92;
            if (i == 116) begin
                Enable  = 1'b0;
                lowLeft = 5;
            end
            if (i >= 300 && !resetHit && Enable && lastDrive && RstN) begin
                resetHit = 1'b1;
                RstN     = 1'b0;
                #1;
                check("async_reset_anode", Anode, 4'hF);
                check("async_reset_cathode", Cathode, 8'hFF);
                check("async_reset_tick", FrameTick, 1'b0);
                q.push_back('{an: 4'hF, ca: 8'hFF, tick: 1'b0});
                lastDrive = 1'b0;
                continue;
            end
            if (i >= 150) begin
                if ($urandom_range(0, 15) == 0) begin
                    pick = $urandom_range(0, 2);
                    seg[$urandom_range(0, 3)] = (pick == 0) ? 8'h00 :
                                                (pick == 1) ? 8'hFF : 8'($urandom);
                end
`ifdef SEG_BLINK_EN
                if ($urandom_range(0, 63) == 0)
                    mask = 4'($urandom);
`endif
                if (Enable && lowLeft == 0 && $urandom_range(0, 299) == 0) begin
                    Enable  = 1'b0;
                    lowLeft = $urandom_range(1, 8);
                end
            end
            applyInputs();
            pushExpected();
        end

        @(negedge Clk100M);
        repeat (2) @(posedge Clk100M);
        #2;
        check("queue_drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
